// File: rtl/bg_trim_reader.sv
// bg_trim_reader: captures the bandgap trim code on every conversion, tracks
// how many consecutive captures agree to flag lock, and shifts out an 18-bit
// snapshot {1, locked, coarse, fine} MSB first on request.
module bg_trim_reader #(
    parameter int STABLE_N = 3,   // consecutive matching captures for lock (1..15)
    parameter int TOL      = 1    // max |fine delta| that still counts as a match (0..255)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] idacCoarse,
    input  logic [7:0] idacFine,
    input  logic       rd_req,
    output logic [7:0] code_coarse,
    output logic [7:0] code_fine,
    output logic       locked,
    output logic [7:0] conv_count,
    output logic       busy,
    output logic       sdo,
    output logic       sdo_frame,
    output logic       done
);

    localparam logic [3:0] SAT_CNT = 4'(STABLE_N);
    localparam logic [3:0] LOCK_AT = 4'(STABLE_N - 1);
    localparam logic [8:0] TOL_W   = 9'(TOL);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    // capture front end
    logic       r_valid_q;
    logic       r_cap;
    logic [7:0] r_cap_c;
    logic [7:0] r_cap_f;

    // captured code and stability tracking
    logic [7:0] r_code_c;
    logic [7:0] r_code_f;
    logic       r_locked;
    logic [7:0] r_conv;
    logic [3:0] r_match_cnt;
    logic       r_have_prev;

    // readout
    state_t      r_state;
    logic [17:0] r_shreg;
    logic [4:0]  r_bitcnt;
    logic        r_sdo;
    logic        r_frame;
    logic        r_busy;
    logic        r_done;

    logic [8:0]  w_diff;
    logic [8:0]  w_absdiff;
    logic        w_match;
    logic [3:0]  w_next_cnt;
    logic [17:0] w_frame;

    // Fine delta in 9-bit two's complement so 0x00 vs 0xFF is 255, not 1.
    assign w_diff     = {1'b0, r_cap_f} - {1'b0, r_code_f};
    assign w_absdiff  = w_diff[8] ? (9'd0 - w_diff) : w_diff;
    assign w_match    = r_have_prev && (r_cap_c == r_code_c) && (w_absdiff <= TOL_W);
    assign w_next_cnt = !w_match                ? 4'd0 :
                        (r_match_cnt >= SAT_CNT) ? SAT_CNT : r_match_cnt + 4'd1;
    assign w_frame    = {1'b1, r_locked, r_code_c, r_code_f};

    // Register valid and latch the input code on its rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_cap     <= 1'b0;
            r_cap_c   <= 8'd0;
            r_cap_f   <= 8'd0;
        end else begin
            r_valid_q <= valid;
            r_cap     <= valid & ~r_valid_q;
            if (valid & ~r_valid_q) begin
                r_cap_c <= idacCoarse;
                r_cap_f <= idacFine;
            end
        end
    end

    // Apply a capture: update code, count, match run and lock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code_c    <= 8'd0;
            r_code_f    <= 8'd0;
            r_locked    <= 1'b0;
            r_conv      <= 8'd0;
            r_match_cnt <= 4'd0;
            r_have_prev <= 1'b0;
        end else if (r_cap) begin
            r_code_c    <= r_cap_c;
            r_code_f    <= r_cap_f;
            r_have_prev <= 1'b1;
            r_match_cnt <= w_next_cnt;
            // A mismatch restarts the run at 0, so STABLE_N=1 still locks on it.
            r_locked    <= (w_next_cnt >= LOCK_AT);
            if (r_conv != 8'hFF)
                r_conv <= r_conv + 8'd1;
        end
    end

    // Readout FSM; the frame register is loaded from pre-capture values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shreg  <= 18'd0;
            r_bitcnt <= 5'd0;
            r_sdo    <= 1'b0;
            r_frame  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (rd_req) begin
                        // start bit goes straight out; shreg holds the rest
                        r_sdo    <= w_frame[17];
                        r_shreg  <= {w_frame[16:0], 1'b0};
                        r_bitcnt <= 5'd17;
                        r_frame  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bitcnt == 5'd0) begin
                        r_sdo   <= 1'b0;
                        r_frame <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_sdo    <= r_shreg[17];
                        r_shreg  <= {r_shreg[16:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 5'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sdo   <= 1'b0;
                    r_frame <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign code_coarse = r_code_c;
    assign code_fine   = r_code_f;
    assign locked      = r_locked;
    assign conv_count  = r_conv;
    assign busy        = r_busy;
    assign sdo         = r_sdo;
    assign sdo_frame   = r_frame;
    assign done        = r_done;

endmodule

// File: tb/tb_bg_trim_reader.sv
// Self-checking bench for bg_trim_reader: directed scenarios plus randomized
// captures and readouts checked against a history-based reference model.
module tb_bg_trim_reader;

    localparam int STABLE_N = 3;
    localparam int TOL      = 1;

    logic       clk = 1'b0;
    logic       reset, valid, rd_req;
    logic [7:0] idacCoarse, idacFine;
    logic [7:0] code_coarse, code_fine, conv_count;
    logic       locked, busy, sdo, sdo_frame, done;

    int checks   = 0;
    int failures = 0;

    // reference model: full history of captured codes since reset
    logic [7:0] mc[$];
    logic [7:0] mf[$];

    bg_trim_reader #(.STABLE_N(STABLE_N), .TOL(TOL)) dut (
        .clk(clk), .reset(reset), .valid(valid),
        .idacCoarse(idacCoarse), .idacFine(idacFine), .rd_req(rd_req),
        .code_coarse(code_coarse), .code_fine(code_fine), .locked(locked),
        .conv_count(conv_count), .busy(busy), .sdo(sdo),
        .sdo_frame(sdo_frame), .done(done)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lock = the trailing run of mutually matching captures is >= STABLE_N long.
    function automatic logic m_locked();
        int k = 0;
        int d;
        if (mc.size() == 0) return 1'b0;
        for (int i = mc.size() - 1; i > 0; i--) begin
            d = int'(mf[i]) - int'(mf[i-1]);
            if (d < 0) d = -d;
            if (mc[i] == mc[i-1] && d <= TOL) k++;
            else break;
        end
        return (k + 1 >= STABLE_N);
    endfunction

    function automatic logic [7:0] m_count();
        return (mc.size() > 255) ? 8'd255 : 8'(mc.size());
    endfunction

    function automatic logic [7:0] m_c();
        return (mc.size() == 0) ? 8'd0 : mc[mc.size()-1];
    endfunction

    function automatic logic [7:0] m_f();
        return (mf.size() == 0) ? 8'd0 : mf[mf.size()-1];
    endfunction

    function automatic logic [17:0] m_frame();
        return {1'b1, m_locked(), m_c(), m_f()};
    endfunction

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; rd_req = 1'b0;
        idacCoarse = 8'd0; idacFine = 8'd0;
        tick(); tick();
        reset = 1'b0;
        mc.delete(); mf.delete();
        tick();
    endtask

    task automatic cap(input logic [7:0] c, input logic [7:0] f);
        idacCoarse = c; idacFine = f; valid = 1'b1;
        tick(); tick(); tick();
        valid = 1'b0;
        tick(); tick();
        mc.push_back(c); mf.push_back(f);
    endtask

    task automatic check_state(input string nm);
        logic [24:0] exp, act;
        exp = {m_c(), m_f(), m_locked(), m_count()};
        act = {code_coarse, code_fine, locked, conv_count};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got c=%h f=%h lk=%b cnt=%0d, want c=%h f=%h lk=%b cnt=%0d",
                     nm, act[24:17], act[16:9], act[8], act[7:0],
                     exp[24:17], exp[16:9], exp[8], exp[7:0]);
        end
    endtask

    // Issue rd_req and check the full frame; optionally re-request at t+10.
    task automatic read_frame(input logic [17:0] exp, input bit inject, input string nm);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int i = 17; i >= 0; i--) begin
            checks++;
            if ({sdo, sdo_frame, busy, done} !== {exp[i], 3'b110}) begin
                failures++;
                $display("FAIL %s bit%0d: got sdo/frm/busy/done=%b, want %b",
                         nm, i, {sdo, sdo_frame, busy, done}, {exp[i], 3'b110});
            end
            rd_req = (inject && i == 8);
            tick();
        end
        rd_req = 1'b0;
        checks++;
        if ({sdo, sdo_frame, busy, done} !== 4'b0011) begin
            failures++;
            $display("FAIL %s done: got sdo/frm/busy/done=%b, want 0011", nm,
                     {sdo, sdo_frame, busy, done});
        end
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({sdo, sdo_frame, busy, done} !== 4'b0000) begin
                failures++;
                $display("FAIL %s idle%0d: got sdo/frm/busy/done=%b, want 0000", nm, j,
                         {sdo, sdo_frame, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset_state");
        cap(8'h33, 8'h44);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mc.delete(); mf.delete();
        checks++;
        if ({code_coarse, code_fine, locked, conv_count, busy, sdo, sdo_frame, done} !== 28'd0) begin
            failures++;
            $display("FAIL reset_midframe: got %h, want 0",
                     {code_coarse, code_fine, locked, conv_count, busy, sdo, sdo_frame, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_nodone: got busy/done=%b, want 00", {busy, done});
        end
        read_frame(18'h20000, 1'b0, "frame_after_reset");
    endtask

    task automatic test_lock();
        do_reset();
        cap(8'h5A, 8'h40); check_state("lock_c1");
        cap(8'h5A, 8'h41); check_state("lock_c2");
        cap(8'h5A, 8'h40); check_state("lock_c3");
        checks++;
        if ({locked, conv_count} !== {1'b1, 8'd3}) begin
            failures++;
            $display("FAIL lock_direct: got lk=%b cnt=%0d, want lk=1 cnt=3", locked, conv_count);
        end
        cap(8'h5B, 8'h40); check_state("lock_break");
        do_reset();
        cap(8'h80, 8'hFF);
        cap(8'h80, 8'h00); check_state("nowrap");
        cap(8'h80, 8'h00); check_state("nowrap_c3");
    endtask

    task automatic test_frame_snapshot();
        do_reset();
        repeat (3) cap(8'hA5, 8'h3C);
        check_state("frame_pre");
        read_frame({1'b1, 1'b1, 8'hA5, 8'h3C}, 1'b0, "frame_content");
        // new code rises one edge before rd_req so both land on the same edge
        idacCoarse = 8'h11; idacFine = 8'h22; valid = 1'b1;
        tick();
        read_frame({1'b1, 1'b1, 8'hA5, 8'h3C}, 1'b1, "snapshot");
        valid = 1'b0;
        mc.push_back(8'h11); mf.push_back(8'h22);
        tick();
        check_state("snapshot_codes");
    endtask

    task automatic test_saturation();
        do_reset();
        idacCoarse = 8'h07; idacFine = 8'h09; valid = 1'b1;
        repeat (50) tick();
        valid = 1'b0;
        tick(); tick();
        mc.push_back(8'h07); mf.push_back(8'h09);
        check_state("level_hold");
        for (int i = 0; i < 300; i++) begin
            valid = 1'b1; tick();
            valid = 1'b0; tick();
            mc.push_back(8'h07); mf.push_back(8'h09);
        end
        tick();
        check_state("saturate");
        checks++;
        if (conv_count !== 8'd255) begin
            failures++;
            $display("FAIL saturate_direct: got %0d, want 255", conv_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] c, f;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            c = 8'h10 + 8'($urandom_range(0, 1));
            f = 8'h80 + 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) f = 8'($urandom);
            cap(c, f);
            check_state($sformatf("rand_cap%0d", n));
            if (n % 8 == 7) read_frame(m_frame(), 1'b0, $sformatf("rand_frame%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_frame_snapshot();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bg_trim_reader.md
# bg_trim_reader

Consumer-side readout block for the bandgap calibration controller. Watches the controller's `valid` strobe and captures the settled `idacCoarse`/`idacFine` trim code on each conversion. Tracks code stability across conversions to flag lock. Serialises a snapshot of the trim and lock status on request for test/readout logic outside the analog macro.

## Interface

Parameters
- `STABLE_N`, default 3: number of consecutive matching captures required to assert `locked`; legal range 1–15.
- `TOL`, default 1: maximum allowed |fine − previous fine| in LSBs for a capture to count as matching; legal range 0–255.

Ports
- `clk`  in  1  system clock, 10 MHz nominal.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  conversion-valid level from the calibration controller; high for several cycles per conversion.
- `idacCoarse`  in  8  coarse trim code from the controller.
- `idacFine`  in  8  fine trim code from the controller.
- `rd_req`  in  1  readout request; sampled only in IDLE.
- `code_coarse`  out  8  last captured coarse code.
- `code_fine`  out  8  last captured fine code.
- `locked`  out  1  stability flag.
- `conv_count`  out  8  number of captures since reset; saturates at 255.
- `busy`  out  1  serial frame in progress, including the DONE cycle.
- `sdo`  out  1  serial data, MSB first.
- `sdo_frame`  out  1  high while `sdo` carries frame bits.
- `done`  out  1  one-cycle pulse after the last frame bit.

## Operation

- Reset (`reset` high at a clock edge): every output and internal register goes to 0, including `code_*`, `locked`, `conv_count`, `sdo`, `sdo_frame`, `busy`, `done`, the match counter, `valid_q`, and the have-previous flag. The FSM returns to IDLE.
- Reset mid-frame aborts the frame immediately. There is no `done` pulse.

Capture path
- A capture event occurs when `valid` = 1 and `valid_q` = 0, where `valid_q` is `valid` registered.
- A capture loads `code_coarse`/`code_fine` from the inputs and increments `conv_count`, saturating at 255.
- Match rule: a capture matches when the have-previous flag is set, coarse equals the previous coarse, and |fine − previous fine| ≤ `TOL`.
  - Compute the difference in 9-bit signed arithmetic. No wrap: 0x00 vs 0xFF is a difference of 255.
- On a match, `match_cnt` increments, saturating at `STABLE_N`.
- On a mismatch, or on the first capture after reset, `match_cnt` ← 0 and `locked` ← 0.
- `locked` ← 1 on the capture that brings `match_cnt` to `STABLE_N − 1`. This means `STABLE_N` consecutive equal codes including the first.
  - With `STABLE_N` = 1, every capture sets `locked`.
- `valid` held high produces exactly one capture. A new capture requires `valid` to drop low first.

Readout FSM: IDLE → SHIFT → DONE → IDLE
- IDLE: when `rd_req` = 1, load the 18-bit shift register with {1'b1, `locked`, `code_coarse`, `code_fine`}, set the bit counter to 17, and go to SHIFT.
- SHIFT: `sdo` = shreg[17] and `sdo_frame` = 1. Shift left each cycle. After the bit with counter = 0, go to DONE.
- DONE: `sdo_frame` = 0, `sdo` = 0, `done` = 1. Go to IDLE.
- `rd_req` outside IDLE is ignored; it is not queued.
- Captures during SHIFT/DONE update `code_*`/`locked` but never the frame in flight.
- Simultaneous capture and accepted `rd_req` in the same cycle: the frame snapshots the pre-capture register values.
- `sdo` = 0 whenever `sdo_frame` = 0.

## Timing

- Capture latency: a rising `valid` sampled at edge n updates `code_*`, `conv_count` and `locked` after edge n+1, i.e. one cycle after the registered edge detect.
- Readout: `rd_req` sampled in IDLE at edge t gives:
  - `busy`/`sdo_frame` high and start bit on `sdo` from t+1;
  - `locked` bit at t+2;
  - coarse[7:0] at t+3…t+10;
  - fine[7:0] at t+11…t+18;
  - `done` = 1, `busy` = 1 at t+19;
  - IDLE again from t+20, earliest next accept at edge t+20.
- Frame length is fixed at 18 cycles. Accept-to-accept period is at least 20 cycles.

## Test plan

- Reset: assert `reset` mid-frame at bit 5 → next cycle all outputs 0, no `done`, FSM IDLE. An `rd_req` afterwards yields a frame with `locked` = 0 and code 0x00/0x00.
- Lock acquisition, TOL = 1, STABLE_N = 3: captures (0x5A,0x40), (0x5A,0x41), (0x5A,0x40) → `locked` = 1 after the third capture, `conv_count` = 3.
  - A fourth capture (0x5B,0x40) → `locked` = 0.
- No wrap in tolerance: captures (0x80,0xFF) then (0x80,0x00) → mismatch, `locked` stays 0.
- Frame content: with code 0xA5/0x3C and `locked` = 1, pulse `rd_req` → `sdo` sequence 1,1,1010_0101,0011_1100 on t+1…t+18, `done` at t+19.
- Snapshot and ignore: `rd_req` coincident with a capture of new code 0x11/0x22 → frame carries the old code, `code_*` reads 0x11/0x22. A second `rd_req` at t+10 produces no new frame.
- Saturation and level-hold: 300 `valid` pulses → `conv_count` = 255. `valid` held high for 50 cycles → exactly one increment.
